// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word-side handshake plus serial-side outputs of the
// bit serializer.
//   word_in/word_valid/word_ready : upstream valid/ready word channel
//   bit_out/bit_valid/last        : serial stream toward the detector
//   busy                          : serializer holds or is shifting a word
// master = upstream/consumer side, slave = serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             last;
  logic             busy;

  modport master (
    output word_in, word_valid,
    input  word_ready, bit_out, bit_valid, last, busy
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, bit_out, bit_valid, last, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the sequence detector.
// Accepts WIDTH-bit words on a valid/ready handshake into a one-entry
// pending buffer and shifts them out one bit per clock, optionally followed
// by GAP idle cycles. A pending word is loaded on the last bit so that
// back-to-back words stream with no bubble.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bit_serializer_if.slave (word_in, word_valid, word_ready,
//          bit_out, bit_valid, last, busy)
// Parameters: WIDTH (>=2), GAP (idle cycles per word), MSB_FIRST.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter int MSB_FIRST = 1
) (
  input logic             clk,
  input logic             rst,
  bit_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GCNT_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] pend;
  logic             pend_full;
  logic [WIDTH-1:0] sr, sr_shift;
  logic             bit_head;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic             hs, load, bit_last;

  // Ready is masked by rst so a word offered during reset is never taken.
  assign bus.word_ready = !pend_full && !rst;
  assign hs             = bus.word_valid && bus.word_ready;
  assign bit_last       = (cnt == CNT_LAST);

  // Output end of the shift register depends on bit order.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign sr_shift = {sr[WIDTH-2:0], 1'b0};
      assign bit_head = sr[WIDTH-1];
    end else begin : g_lsb
      assign sr_shift = {1'b0, sr[WIDTH-1:1]};
      assign bit_head = sr[0];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_full) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_last) begin
          if (GAP > 0)        state_nxt = S_GAP;
          else if (pend_full) load      = 1'b1;   // chain next word, stay in SHIFT
          else                state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gcnt == GCNT_LAST) begin
          if (pend_full) begin
            load      = 1'b1;
            state_nxt = S_SHIFT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pend      <= '0;
      pend_full <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
      gcnt      <= '0;
    end else begin
      state <= state_nxt;

      if (hs) pend <= bus.word_in;
      // A load empties PEND unless a new word lands in the same cycle.
      if (load)    pend_full <= hs;
      else if (hs) pend_full <= 1'b1;

      if (load) begin
        sr  <= pend;
        cnt <= '0;
      end else if (state == S_SHIFT) begin
        sr  <= sr_shift;
        cnt <= cnt + 1'b1;
      end

      if (state == S_SHIFT && bit_last) gcnt <= '0;
      else if (state == S_GAP)          gcnt <= gcnt + 1'b1;
    end
  end

  assign bus.bit_valid = (state == S_SHIFT);
  assign bus.bit_out   = bus.bit_valid & bit_head;
  assign bus.last      = bus.bit_valid & bit_last;
  assign bus.busy      = (state != S_IDLE) | pend_full;
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer. Three instances cover the parameter sets:
//   dut0 GAP=0 MSB first, dut1 GAP=2 MSB first, dut2 GAP=0 LSB first.
// Every accepted word pushes its expected {bit,last} sequence into a
// per-instance queue; each valid serial bit pops and compares.
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) if0 ();
  bit_serializer_if #(.WIDTH(8)) if1 ();
  bit_serializer_if #(.WIDTH(8)) if2 ();

  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bit_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(0)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [2:0]      vin = '0;
  logic [2:0][7:0] win = '0;
  logic [2:0]      bv, bo, ls, rdy, bsy;

  assign if0.word_valid = vin[0];
  assign if1.word_valid = vin[1];
  assign if2.word_valid = vin[2];
  assign if0.word_in    = win[0];
  assign if1.word_in    = win[1];
  assign if2.word_in    = win[2];
  assign bv  = {if2.bit_valid,  if1.bit_valid,  if0.bit_valid};
  assign bo  = {if2.bit_out,    if1.bit_out,    if0.bit_out};
  assign ls  = {if2.last,       if1.last,       if0.last};
  assign rdy = {if2.word_ready, if1.word_ready, if0.word_ready};
  assign bsy = {if2.busy,       if1.busy,       if0.busy};

  int checks = 0;
  int errors = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];
  logic [2:0] trv[$];
  int         hs_cnt [3];
  logic [2:0] hs_last;

  function automatic void push_word(int d, logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      logic [1:0] e;
      if (d == 2) e = {w[i], i == 7};
      else        e = {w[7-i], i == 7};
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endfunction

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [1:0] pop_q(int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int count_valid(int d);
    int n = 0;
    foreach (trv[i]) if (trv[i][d]) n++;
    return n;
  endfunction

  // Lengths of alternating bit_valid runs from the first valid cycle on,
  // ignoring the idle tail, e.g. "8 2 8".
  function automatic string runs_str(int d);
    string s = "";
    int    cur = 0;
    logic  pv = 1'b0;
    bit    started = 1'b0;
    foreach (trv[i]) begin
      logic v;
      v = trv[i][d];
      if (!started) begin
        if (v) begin started = 1'b1; cur = 1; pv = 1'b1; end
      end else if (v === pv) begin
        cur++;
      end else begin
        s   = (s == "") ? $sformatf("%0d", cur) : {s, $sformatf(" %0d", cur)};
        cur = 1;
        pv  = v;
      end
    end
    if (started && pv) s = (s == "") ? $sformatf("%0d", cur) : {s, $sformatf(" %0d", cur)};
    return s;
  endfunction

  // Called at a negedge with inputs set; returns at the next negedge after
  // scoring whatever the instances show in that cycle.
  task automatic step();
    logic [1:0] e;
    #1;
    hs_last = vin & rdy;
    for (int d = 0; d < 3; d++) begin
      if (hs_last[d]) begin
        push_word(d, win[d]);
        hs_cnt[d]++;
      end
    end
    @(negedge clk);
    trv.push_back(bv);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (bv[d]) begin
        if (qsize(d) == 0) begin
          errors++;
          $display("FAIL serial_d%0d unexpected bit got=%b required none", d, bo[d]);
        end else begin
          e = pop_q(d);
          if ({bo[d], ls[d]} !== e)
            begin errors++; $display("FAIL serial_d%0d bit/last got=%b%b required %b", d, bo[d], ls[d], e); end
        end
      end else if (bo[d] !== 1'b0 || ls[d] !== 1'b0) begin
        errors++;
        $display("FAIL idle_d%0d bit_out/last got=%b%b required 00", d, bo[d], ls[d]);
      end
    end
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size() != 0 || bsy != 3'b000) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0 || bsy !== 3'b000) begin
      errors++;
      $display("FAIL drain got queued=%0d busy=%b required 0 and 000",
               q0.size() + q1.size() + q2.size(), bsy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vin = '0;
    step();
    step();
    checks++;
    if ({bv, bo, ls, bsy, rdy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b o=%b l=%b busy=%b rdy=%b required all 0", bv, bo, ls, bsy, rdy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy !== 3'b111) begin errors++; $display("FAIL reset_release_ready got=%b required 111", rdy); end
  endtask

  task automatic test_single_msb();
    logic [9:0] got;
    trv.delete();
    vin[0] = 1'b1;
    win[0] = 8'hB4;
    step();
    vin[0] = 1'b0;
    repeat (9) step();
    for (int i = 0; i < 10; i++) got[i] = trv[i][0];
    checks++;
    if (got !== 10'b0111111110) begin
      errors++;
      $display("FAIL single_valid_window got=%b required 0111111110 (cycle k+1 is lsb)", got);
    end
    checks++;
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b required 0", bsy[0]); end
    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL single_all_bits got left=%0d required 0", q0.size()); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    trv.delete();
    hs_cnt[0] = 0;
    vin[0] = 1'b1;
    win[0] = 8'hFF;
    step();
    checks++;
    if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_pend_full got=%b required 0", rdy[0]); end
    win[0] = 8'h00;
    while (hs_cnt[0] < 2 && n < 20) begin step(); n++; end
    vin[0] = 1'b0;
    drain(40);
    checks++;
    if (hs_cnt[0] != 2) begin errors++; $display("FAIL b2b_handshakes got=%0d required 2", hs_cnt[0]); end
    checks++;
    if (runs_str(0) != "16") begin errors++; $display("FAIL b2b_runs got=%s required 16", runs_str(0)); end
  endtask

  task automatic test_gap();
    int n = 0;
    trv.delete();
    hs_cnt[1] = 0;
    vin[1] = 1'b1;
    win[1] = 8'hA5;
    step();
    win[1] = 8'h3C;
    while (hs_cnt[1] < 2 && n < 20) begin step(); n++; end
    vin[1] = 1'b0;
    drain(40);
    checks++;
    if (hs_cnt[1] != 2) begin errors++; $display("FAIL gap_handshakes got=%0d required 2", hs_cnt[1]); end
    checks++;
    if (runs_str(1) != "8 2 8") begin errors++; $display("FAIL gap_runs got=%s required 8 2 8", runs_str(1)); end
  endtask

  task automatic test_lsb();
    trv.delete();
    hs_cnt[2] = 0;
    vin[2] = 1'b1;
    win[2] = 8'h01;
    step();
    vin[2] = 1'b0;
    drain(20);
    checks++;
    if (runs_str(2) != "8") begin errors++; $display("FAIL lsb_runs got=%s required 8", runs_str(2)); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    trv.delete();
    hs_cnt[0] = 0;
    vin[0] = 1'b1;
    win[0] = 8'hAA;
    step();
    win[0] = 8'h55;
    while (count_valid(0) < 4 && n < 20) begin
      step();
      if (hs_cnt[0] >= 2) vin[0] = 1'b0;
      n++;
    end
    checks++;
    if (hs_cnt[0] != 2) begin errors++; $display("FAIL rstmid_pending got=%0d handshakes required 2", hs_cnt[0]); end
    // Reset during the 4th bit, with a word offered that must be refused.
    rst    = 1'b1;
    vin[0] = 1'b1;
    win[0] = 8'hC3;
    step();
    checks++;
    if ({bv[0], bo[0], bsy[0]} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_flush got v/o/busy=%b%b%b required 000", bv[0], bo[0], bsy[0]);
    end
    q0.delete();
    vin[0] = 1'b0;
    rst    = 1'b0;
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b required 1", rdy[0]); end
    trv.delete();
    repeat (20) step();
    checks++;
    if (count_valid(0) != 0) begin errors++; $display("FAIL rstmid_no_resume got=%0d bits required 0", count_valid(0)); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int low = 0;
    hs_cnt[0] = 0;
    vin[0] = 1'b1;
    win[0] = 8'hF0;
    step();
    win[0] = 8'h0F;
    while (hs_cnt[0] < 2 && n < 20) begin step(); n++; end
    win[0] = 8'h3C;
    n = 0;
    while (n < 30) begin
      step();
      n++;
      if (hs_last[0]) break;
      low++;
    end
    vin[0] = 1'b0;
    checks++;
    if (low < 5) begin errors++; $display("FAIL bp_ready_low got=%0d cycles required >=5", low); end
    checks++;
    if (hs_cnt[0] != 3) begin errors++; $display("FAIL bp_handshakes got=%0d required 3", hs_cnt[0]); end
    drain(60);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_msb();
    drain(20);
    test_back_to_back();
    test_gap();
    test_lsb();
    test_reset_mid();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired required completion");
    $fatal(1);
  end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence detector: accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a serial line, with a bit_valid qualifier and last-bit marker. bit_out connects directly to the detector's serial input `i`. The detector samples every clock, so bit_out is forced to 0 whenever no bit is being shifted. A one-entry pending buffer allows back-to-back words with no bubble.

## Interface
- WIDTH, 8: word width in bits; must be ≥ 2.
- GAP, 0: idle cycles inserted after every word; GAP = 0 means none.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- word_in  in  WIDTH  data word; sampled on handshake.
- word_valid  in  1  upstream has a word on word_in.
- word_ready  out  1  pending buffer empty; handshake = word_valid & word_ready at a rising edge.
- bit_out  out  1  current serial bit; 0 when bit_valid = 0.
- bit_valid  out  1  bit_out carries a data bit this cycle.
- last  out  1  bit_out is the final bit of its word.
- busy  out  1  word pending or state ≠ IDLE.

## Operation
- Storage:
  - PEND register with a pend_full flag.
  - Shift register SR (WIDTH bits).
  - Bit counter cnt, $clog2(WIDTH) bits.
  - Gap counter gcnt, $clog2(GAP+1) bits.
- Handshake:
  - word_ready = !pend_full & !rst.
  - On handshake, PEND ← word_in and pend_full ← 1.
  - Words are never dropped or duplicated.
- Load: copies PEND into SR, sets cnt ← 0 and clears pend_full.
  - Exception: a handshake in the same cycle refills PEND, so pend_full stays 1.
- States:
  - IDLE: if pend_full, load and go to SHIFT; else stay.
  - SHIFT: each cycle, shift SR one position toward the output end and increment cnt.
    - At cnt = WIDTH-1 with GAP > 0: gcnt ← 0, go to GAP.
    - At cnt = WIDTH-1 with GAP = 0: if pend_full, load and stay in SHIFT (no bubble); else go to IDLE.
  - GAP: increment gcnt; at gcnt = GAP-1, load and go to SHIFT if pend_full, else go to IDLE.
- Outputs (combinational from registers):
  - bit_valid = (state == SHIFT).
  - bit_out = bit_valid ? (MSB_FIRST ? SR[WIDTH-1] : SR[0]) : 0.
  - last = bit_valid & (cnt == WIDTH-1).
  - busy = (state ≠ IDLE) | pend_full.
- Reset values: state IDLE, SR 0, cnt 0, gcnt 0, pend_full 0, PEND 0.
  - Hence bit_out 0, bit_valid 0, last 0, busy 0, and word_ready 0 while rst = 1.
- Reset mid-operation: the word being shifted and any pending word are discarded. No partial word resumes.
- rst has priority over a simultaneous handshake; that word is not accepted.

## Timing
- Handshake at edge k → pend_full = 1 in cycle k+1 → load at edge k+1 → first bit valid in cycle k+2 (latency 2 from IDLE).
- A word occupies exactly WIDTH consecutive bit_valid cycles; last is high on the WIDTH-th.
- Back-to-back (GAP = 0, next word pending): the next word's first bit immediately follows last; throughput is 1 bit/cycle.
- GAP > 0: exactly GAP cycles with bit_valid = 0 between words, if the next word is pending.
- word_ready may rise the cycle after a load; upstream may hold word_valid high indefinitely.
- From rst release, word_ready = 1 in the first cycle.

## Test plan
- **Single word, MSB first.** WIDTH=8, MSB_FIRST=1, GAP=0; handshake 8'hB4 at edge k.
  - Required: bit_out = 1,0,1,1,0,1,0,0 in cycles k+2..k+9; last only at k+9; bit_valid = 0 and busy = 0 at k+10.
- **Back-to-back.** Hold word_valid with 8'hFF then 8'h00.
  - Required: 16 contiguous bit_valid cycles (8 ones, then 8 zeros) with no bubble.
  - Required: word_ready low while PEND is full; exactly two handshakes.
- **Gap insertion.** GAP=2; two words queued.
  - Required: exactly 2 cycles of bit_valid = 0 and bit_out = 0 between the first word's last and the second word's first bit.
- **LSB first.** MSB_FIRST=0; word 8'h01.
  - Required: first valid bit = 1, next seven = 0; last on the 8th.
- **Reset mid-word.** Assert rst during the 4th bit of 8'hAA while 8'h55 is pending.
  - Required: next cycle bit_valid = 0, bit_out = 0, busy = 0.
  - Required: word_ready = 1 in the first cycle after release; neither word ever appears on bit_out.
- **Backpressure.** word_valid asserted with word_ready low for 5 cycles, word_in stable at 8'h3C.
  - Required: accepted in the first cycle ready is high; serialized once, unaltered.
